cla_serial_ctrl: RTL

Sequencing controller that drives the 5-bit carry-lookahead adder to perform multi-word (multi-precision) additions, one 5-bit slice per pass, least-significant word first. It accepts operand word pairs on a valid/ready input stream and registers them onto the CLA's operand inputs. It carries the CLA carry-out forward as the next slice's carry-in and returns sum words on a valid/ready output stream. It sits between the operand source and the result sink, and owns the CLA instance's inputs exclusively.

---
 rtl/cla_serial_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/cla_serial_ctrl.sv
// Multi-word add sequencer: feeds one WIDTH-bit slice per pass to an external CLA, LS word first.
// Latency: operand accept -> EVAL -> OUT; with out_ready held high one word completes every 3 cycles.
// Backpressure: in_ready only in LOAD; out_ready low holds OUT (and all outputs) indefinitely.
module cla_serial_ctrl #(
  parameter int WIDTH = 5,
  parameter int LEN_W = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             cin,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] cla_a,
  output logic [WIDTH-1:0] cla_b,
  output logic             cla_cin,
  input  logic [WIDTH-1:0] cla_sum,
  input  logic             cla_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             done,
  output logic             carry_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EVAL = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] remaining;

  // Single FSM: cla_cin doubles as the running carry register, so the CLA
  // always sees the carry that belongs to the slice currently loaded.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      cla_a     <= '0;
      cla_b     <= '0;
      cla_cin   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              remaining <= len;
              cla_cin   <= cin;
              busy      <= 1'b1;
              in_ready  <= 1'b1;
              state     <= LOAD;
            end else begin
              // Zero-length operation: the result is just the carry-in.
              carry_out <= cin;
              done      <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (in_valid) begin
            cla_a    <= in_a;
            cla_b    <= in_b;
            in_ready <= 1'b0;
            state    <= EVAL;
          end
        end

        EVAL: begin
          // The CLA has had a full cycle to settle on the registered operands.
          out_sum   <= cla_sum;
          cla_cin   <= cla_cout;
          out_valid <= 1'b1;
          out_last  <= (remaining == LEN_W'(1));
          state     <= OUT;
        end

        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              carry_out <= cla_cin;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              in_ready <= 1'b1;
              state    <= LOAD;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
